// File: rtl/vram_scan_arbiter_if.sv
// vram_scan_arbiter_if: writer handshakes and framebuffer RAM bus shared by the scanout arbiter.
//   w0_*/w1_*  writer request, word address, data and same-cycle grant
//   ram_*      single-port synchronous RAM access; ram_rdata is valid one cycle after a read
//   master: writers + RAM side, slave: the arbiter
interface vram_scan_arbiter_if #(parameter int ADDR_W = 15);
   logic              w0_req, w1_req;
   logic [ADDR_W-1:0] w0_addr, w1_addr;
   logic [15:0]       w0_data, w1_data;
   logic              w0_gnt, w1_gnt;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [15:0]       ram_wdata, ram_rdata;
   modport master (
      output w0_req, w1_req, w0_addr, w1_addr, w0_data, w1_data, ram_rdata,
      input  w0_gnt, w1_gnt, ram_en, ram_we, ram_addr, ram_wdata
   );
   modport slave (
      input  w0_req, w1_req, w0_addr, w1_addr, w0_data, w1_data, ram_rdata,
      output w0_gnt, w1_gnt, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: shares one framebuffer RAM between fixed-slot scanout fetches and two round-robin writers.
//   clk, reset   pixel clock, asynchronous active-high reset
//   x, y, en     sync generator position and visible-region flag
//   bus          writer handshakes and RAM port (slave side)
//   pix          serialised pixel for the current x/y
//   frame_start  one-cycle pulse after x==0, y==0 is sampled
module vram_scan_arbiter #(
   parameter int H_TOTAL        = 800,
   parameter int V_TOTAL        = 525,
   parameter int V_ACTIVE       = 480,
   parameter int WORDS_PER_LINE = 40,
   parameter int ADDR_W         = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [9:0]          x,
   input  logic [9:0]          y,
   input  logic                en,
   vram_scan_arbiter_if.slave  bus,
   output logic                pix,
   output logic                frame_start
);
   localparam logic [9:0]        X_LINE      = 10'(H_TOTAL - 2);
   localparam logic [9:0]        Y_LAST      = 10'(V_TOTAL - 1);
   localparam logic [9:0]        Y_ACT       = 10'(V_ACTIVE);
   localparam logic [9:0]        X_LAST_WORD = 10'(16 * (WORDS_PER_LINE - 1));
   localparam logic [ADDR_W-1:0] WPL         = ADDR_W'(WORDS_PER_LINE);
   logic [9:0]        y_next;
   logic [10:0]       x_ahead;
   logic              line_fetch, word_fetch, fetch, fetch_d1, ptr, sel1, wr;
   logic [ADDR_W-1:0] fetch_addr;
   logic [15:0]       shreg;
   // word 0 of the next line is fetched near the end of the current one; the
   // remaining words are fetched two pixels ahead of their first column
   assign y_next     = (y == Y_LAST) ? '0 : y + 10'd1;
   assign line_fetch = (x == X_LINE) && (y_next < Y_ACT);
   assign word_fetch = (x[3:0] == 4'd14) && (x < X_LAST_WORD) && (y < Y_ACT);
   assign fetch      = line_fetch | word_fetch;
   assign x_ahead    = {1'b0, x} + 11'd2;
   assign fetch_addr = line_fetch ? ADDR_W'(y_next) * WPL
                                  : ADDR_W'(y) * WPL + ADDR_W'(x_ahead[10:4]);
   // ptr=1 means w1 is preferred on a tie; writes are suppressed during reset
   always_comb begin
      sel1          = bus.w1_req & (~bus.w0_req | ptr);
      wr            = ~reset & ~fetch & (bus.w0_req | bus.w1_req);
      bus.w0_gnt    = wr & ~sel1;
      bus.w1_gnt    = wr & sel1;
      bus.ram_en    = fetch | wr;
      bus.ram_we    = wr;
      bus.ram_addr  = fetch ? fetch_addr : sel1 ? bus.w1_addr : bus.w0_addr;
      bus.ram_wdata = sel1 ? bus.w1_data : bus.w0_data;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr         <= 1'b0;
         fetch_d1    <= 1'b0;
         shreg       <= '0;
         frame_start <= 1'b0;
      end else begin
         if (wr) ptr <= ~sel1;
         fetch_d1    <= fetch;
         shreg       <= fetch_d1 ? bus.ram_rdata : en ? {shreg[14:0], 1'b0} : shreg;
         frame_start <= (x == 10'd0) && (y == 10'd0);
      end
   end
   assign pix = en & shreg[15];
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb_vram_scan_arbiter: directed checks of scanout timing, writer arbitration and reset behaviour.
module tb_vram_scan_arbiter;
   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] x, y;
   logic       en;
   logic       pix, frame_start;
   int         total = 0;
   int         bad = 0;
   vram_scan_arbiter_if #(.ADDR_W(15)) bus();
   vram_scan_arbiter dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .en(en),
      .bus(bus), .pix(pix), .frame_start(frame_start)
   );
   always #5 clk = ~clk;
   // RAM model: unwritten word n reads back as n
   logic [15:0] mem [0:32767];
   bit          wv  [0:32767];
   always @(posedge clk)
      if (bus.ram_en) begin
         if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            wv[bus.ram_addr]  <= 1'b1;
         end else
            bus.ram_rdata <= wv[bus.ram_addr] ? mem[bus.ram_addr] : 16'(bus.ram_addr);
      end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic set_xy(input int nx, input int ny);
      x  = 10'(nx);
      y  = 10'(ny);
      en = (nx < 640) && (ny < 480);
      #1;
   endtask
   task automatic step();
      int nx, ny;
      @(posedge clk);
      #1;
      nx = (x == 10'd799) ? 0 : int'(x) + 1;
      ny = (nx == 0) ? ((y == 10'd524) ? 0 : int'(y) + 1) : int'(y);
      set_xy(nx, ny);
   endtask
   initial begin
      logic [15:0] w;
      int xi;
      reset = 1'b1;
      bus.w0_req = 0; bus.w1_req = 0;
      bus.w0_addr = '0; bus.w1_addr = '0;
      bus.w0_data = '0; bus.w1_data = '0;
      set_xy(0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pix", pix, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_gnt", {bus.w0_gnt, bus.w1_gnt}, 0);
      reset = 1'b0;
      // first fetch of the frame and frame_start pulse
      set_xy(796, 524);
      step();
      chk("idle_ram_en", bus.ram_en, 0);
      step();
      chk("f0_ram_en", bus.ram_en, 1);
      chk("f0_ram_we", bus.ram_we, 0);
      chk("f0_ram_addr", bus.ram_addr, 0);
      step();
      step();
      chk("fs_x0", frame_start, 0);
      step();
      chk("fs_x1", frame_start, 1);
      step();
      chk("fs_x2", frame_start, 0);
      // scan line 1 with word(n)=n
      set_xy(790, 0);
      for (int i = 0; i < 650; i++) begin
         xi = int'(x);
         if (y == 10'd0 && xi == 798) begin
            chk("l1_f0_en", bus.ram_en, 1);
            chk("l1_f0_addr", bus.ram_addr, 40);
         end
         if (y == 10'd1 && xi < 640) begin
            w = 16'(40 + xi / 16);
            chk("l1_pix", pix, w[15 - xi % 16]);
            if (xi % 16 == 14 && xi < 624) begin
               chk("l1_fetch_en", {bus.ram_en, bus.ram_we}, 2'b10);
               chk("l1_fetch_addr", bus.ram_addr, 40 + (xi + 2) / 16);
            end
            if (xi == 638) chk("l1_x638_idle", bus.ram_en, 0);
         end
         step();
      end
      chk("l1_x640_pix", pix, 0);
      // both writers during vblank alternate, starting with w0
      bus.w0_req = 1; bus.w0_addr = 15'h7000; bus.w0_data = 16'h1111;
      bus.w1_req = 1; bus.w1_addr = 15'h7001; bus.w1_data = 16'h2222;
      set_xy(100, 490);
      for (int i = 0; i < 6; i++) begin
         chk("rr_gnt", {bus.w0_gnt, bus.w1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
         chk("rr_ram", {bus.ram_en, bus.ram_we}, 2'b11);
         chk("rr_addr", bus.ram_addr, (i % 2 == 0) ? 32'h7000 : 32'h7001);
         chk("rr_wdata", bus.ram_wdata, (i % 2 == 0) ? 32'h1111 : 32'h2222);
         step();
      end
      // both requesting in a fetch cycle are deferred
      set_xy(30, 5);
      chk("defer_gnt", {bus.w0_gnt, bus.w1_gnt}, 0);
      chk("defer_ram", {bus.ram_en, bus.ram_we}, 2'b10);
      chk("defer_addr", bus.ram_addr, 202);
      step();
      chk("defer_next_gnt", {bus.w0_gnt, bus.w1_gnt}, 2'b10);
      step();
      bus.w0_req = 0;
      #1;
      chk("lone_w1_gnt", {bus.w0_gnt, bus.w1_gnt}, 2'b01);
      chk("lone_w1_addr", bus.ram_addr, 32'h7001);
      bus.w1_req = 0;
      // w0 request arriving on a fetch slot
      bus.w0_req = 1; bus.w0_addr = 15'h1234; bus.w0_data = 16'hABCD;
      set_xy(14, 5);
      chk("x14_gnt", bus.w0_gnt, 0);
      chk("x14_we", bus.ram_we, 0);
      chk("x14_addr", bus.ram_addr, 201);
      step();
      chk("x15_gnt", bus.w0_gnt, 1);
      chk("x15_we", bus.ram_we, 1);
      chk("x15_addr", bus.ram_addr, 32'h1234);
      chk("x15_wdata", bus.ram_wdata, 32'hABCD);
      step();
      bus.w0_req = 0;
      #1;
      chk("x16_idle", bus.ram_en, 0);
      // line 2 words: 0xFFFF at 81, zero elsewhere
      set_xy(100, 500);
      for (int a = 80; a < 120; a++) begin
         bus.w0_req  = 1;
         bus.w0_addr = 15'(a);
         bus.w0_data = (a == 81) ? 16'hFFFF : 16'h0000;
         #1;
         chk("fill_gnt", bus.w0_gnt, 1);
         chk("fill_addr", bus.ram_addr, a);
         step();
      end
      bus.w0_req = 0;
      set_xy(790, 1);
      for (int i = 0; i < 650; i++) begin
         xi = int'(x);
         if (y == 10'd2 && xi < 640) chk("l2_pix", pix, (xi >= 16 && xi < 32) ? 1 : 0);
         step();
      end
      // reset in the middle of a visible line
      set_xy(280, 101);
      while (x != 10'd300) step();
      chk("pre_rst_pix", pix, 1);
      reset = 1'b1;
      bus.w0_req = 1; bus.w0_addr = 15'h0500; bus.w0_data = 16'h5555;
      #1;
      chk("rst_mid_pix", pix, 0);
      chk("rst_mid_gnt", bus.w0_gnt, 0);
      chk("rst_mid_we", bus.ram_we, 0);
      step();
      chk("rst_hold_gnt", bus.w0_gnt, 0);
      chk("rst_hold_pix", pix, 0);
      step();
      reset = 1'b0;
      bus.w0_req = 0;
      #1;
      chk("rel_fetch_addr", bus.ram_addr, 4059);
      chk("rel_pix", pix, 0);
      for (int i = 303; i <= 308; i++) begin
         step();
         chk("rel_gnt", {bus.w0_gnt, bus.w1_gnt}, 0);
         chk("rel_pix_seq", pix, (i == 308) ? 1 : 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
